// File: rtl/ysyx_22040237_lsu_pkg.sv
// ysyx_22040237_lsu_pkg: info-bus group codes, LS field indices, LSU state and access-size types
package ysyx_22040237_lsu_pkg;
    localparam logic [2:0] GRP_ALU = 3'b001;
    localparam logic [2:0] GRP_BJP = 3'b010;
    localparam logic [2:0] GRP_LS  = 3'b100;
    localparam int LS_LOAD  = 3;
    localparam int LS_STORE = 4;
    localparam int LS_USIGN = 5;
    localparam int LS_BYTE  = 6;
    localparam int LS_DB    = 7;
    localparam int LS_WORD  = 8;
    localparam int LS_DW    = 9;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_DONE} lsu_state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} lsu_size_e;
    // widest requested size wins; no size bit at all means byte
    function automatic lsu_size_e size_of(input logic dw, input logic word, input logic half);
        return dw ? SZ_D : word ? SZ_W : half ? SZ_H : SZ_B;
    endfunction
    // off is ea[2:0]; an access is aligned when ea is a multiple of its size
    function automatic logic is_misaligned(input lsu_size_e size, input logic [2:0] off);
        return size == SZ_D ? off != 3'd0 : size == SZ_W ? off[1:0] != 2'd0 : size == SZ_H ? off[0] : 1'b0;
    endfunction
endpackage

// File: rtl/ysyx_22040237_lsu_align.sv
// ysyx_22040237_lsu_align: byte-lane alignment of store data/strobes and load extraction/extension
module ysyx_22040237_lsu_align
    import ysyx_22040237_lsu_pkg::*;
(
    input  lsu_size_e   size,
    input  logic [2:0]  off,
    input  logic        usign,
    input  logic [63:0] store_data,
    input  logic [63:0] load_data,
    output logic [7:0]  wmask,
    output logic [63:0] wdata,
    output logic [63:0] ldata
);
    logic [7:0]  size_mask;
    logic [63:0] sh;
    assign size_mask = size == SZ_D ? 8'hFF : size == SZ_W ? 8'h0F : size == SZ_H ? 8'h03 : 8'h01;
    assign wmask     = size_mask << off;
    assign wdata     = store_data << {off, 3'b000};
    assign sh        = load_data >> {off, 3'b000};
    // word loads always sign-extend; double words pass through untouched
    assign ldata = size == SZ_D ? sh
                 : size == SZ_W ? {{32{sh[31]}}, sh[31:0]}
                 : size == SZ_H ? (usign ? {48'b0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]})
                 : (usign ? {56'b0, sh[7:0]} : {{56{sh[7]}}, sh[7:0]});
endmodule

// File: rtl/ysyx_22040237_lsu.sv
// ysyx_22040237_lsu: multi-cycle load/store unit with a single-outstanding req/gnt/rsp memory port
module ysyx_22040237_lsu
    import ysyx_22040237_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [14:0] exu_info_bus_i,
    input  logic [63:0] op1_i,
    input  logic [63:0] op2_i,
    input  logic [63:0] op2_jp_i,
    input  logic [4:0]  rd_idx_i,
    input  logic        rd_wr_en_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    output logic [7:0]  mem_wmask_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [63:0] mem_rdata_i,
    output logic        wb_valid_o,
    input  logic        wb_ready_i,
    output logic        wb_en_o,
    output logic [4:0]  wb_rd_idx_o,
    output logic [63:0] wb_data_o,
    output logic        misalign_o
);
    lsu_state_e  state, state_nxt;
    lsu_size_e   size_in, size_q;
    logic [63:0] ea, ea_q, sdata_q, result_q, wdata, ldata;
    logic [7:0]  wmask;
    logic [4:0]  rd_q;
    logic        accept, is_ls, mis_in, load_q, usign_q, wen_q, mis_q;
    logic        unused_ok;

    assign ea        = op1_i + op2_i;
    assign size_in   = size_of(exu_info_bus_i[LS_DW], exu_info_bus_i[LS_WORD], exu_info_bus_i[LS_DB]);
    assign mis_in    = is_misaligned(size_in, ea[2:0]);
    assign is_ls     = exu_info_bus_i[2:0] == GRP_LS && (exu_info_bus_i[LS_LOAD] ^ exu_info_bus_i[LS_STORE]);
    assign accept    = in_valid_i && state == S_IDLE;
    assign unused_ok = ^{exu_info_bus_i[14:10], exu_info_bus_i[LS_BYTE]};

    ysyx_22040237_lsu_align u_align (
        .size       (size_q),
        .off        (ea_q[2:0]),
        .usign      (usign_q),
        .store_data (sdata_q),
        .load_data  (mem_rdata_i),
        .wmask      (wmask),
        .wdata      (wdata),
        .ldata      (ldata)
    );

    // state register; reset abandons any in-flight access
    always_ff @(posedge clk) begin
        state <= rst ? S_IDLE : state_nxt;
    end

    // next state: misaligned ops skip memory, stores finish on grant, loads wait for the response
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && is_ls) state_nxt = mis_in ? S_DONE : S_REQ;
            S_REQ:   if (mem_gnt_i) state_nxt = load_q ? S_RSP : S_DONE;
            S_RSP:   if (mem_rvalid_i) state_nxt = S_DONE;
            default: if (wb_ready_i) state_nxt = S_IDLE;
        endcase
    end

    // operand capture at accept and load result capture in RSP
    always_ff @(posedge clk) begin
        if (rst) begin
            ea_q     <= '0;
            size_q   <= SZ_B;
            load_q   <= 1'b0;
            usign_q  <= 1'b0;
            wen_q    <= 1'b0;
            rd_q     <= '0;
            sdata_q  <= '0;
            mis_q    <= 1'b0;
            result_q <= '0;
        end else if (accept && is_ls) begin
            ea_q     <= ea;
            size_q   <= size_in;
            load_q   <= exu_info_bus_i[LS_LOAD];
            usign_q  <= exu_info_bus_i[LS_USIGN];
            wen_q    <= exu_info_bus_i[LS_LOAD] && rd_wr_en_i && rd_idx_i != 5'd0 && !mis_in;
            rd_q     <= rd_idx_i;
            sdata_q  <= op2_jp_i;
            mis_q    <= mis_in;
            result_q <= '0;
        end else if (state == S_RSP && mem_rvalid_i) begin
            result_q <= ldata;
        end
    end

    // outputs are driven only in the state that owns them, zero elsewhere
    always_comb begin
        in_ready_o  = state == S_IDLE;
        mem_req_o   = state == S_REQ;
        mem_we_o    = state == S_REQ && !load_q;
        mem_addr_o  = state == S_REQ ? {ea_q[63:3], 3'b000} : '0;
        mem_wdata_o = state == S_REQ && !load_q ? wdata : '0;
        mem_wmask_o = state == S_REQ && !load_q ? wmask : '0;
        wb_valid_o  = state == S_DONE;
        wb_en_o     = state == S_DONE && wen_q;
        wb_rd_idx_o = state == S_DONE ? rd_q : '0;
        wb_data_o   = state == S_DONE ? result_q : '0;
        misalign_o  = state == S_DONE && mis_q;
    end
endmodule

// File: tb/tb_ysyx_22040237_lsu.sv
// tb_ysyx_22040237_lsu: directed and randomized checks of the LSU against an arithmetic reference model
module tb_ysyx_22040237_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [14:0] exu_info_bus_i = '0;
    logic [63:0] op1_i = '0, op2_i = '0, op2_jp_i = '0;
    logic [4:0]  rd_idx_i = '0;
    logic        rd_wr_en_i = 1'b0;
    logic        mem_req_o, mem_we_o;
    logic [63:0] mem_addr_o, mem_wdata_o;
    logic [7:0]  mem_wmask_o;
    logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [63:0] mem_rdata_i = '0;
    logic        wb_valid_o, wb_ready_i = 1'b0, wb_en_o, misalign_o;
    logic [4:0]  wb_rd_idx_o;
    logic [63:0] wb_data_o;
    int pass_cnt = 0, total_cnt = 0;

    typedef struct {
        bit mis; logic [63:0] addr; logic [7:0] wmask; logic [63:0] wdata; logic [63:0] ld; bit wen;
    } exp_t;
    typedef struct {
        bit timeout, ready_before, busy_ready, req_seen, req_unstable, we, wb_en, mis, wb_unstable, ready_after, wbv_after;
        logic [63:0] addr, wdata, data; logic [7:0] wmask; logic [4:0] idx; int lat;
    } obs_t;

    ysyx_22040237_lsu dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .exu_info_bus_i(exu_info_bus_i), .op1_i(op1_i), .op2_i(op2_i), .op2_jp_i(op2_jp_i),
        .rd_idx_i(rd_idx_i), .rd_wr_en_i(rd_wr_en_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_en_o(wb_en_o),
        .wb_rd_idx_o(wb_rd_idx_o), .wb_data_o(wb_data_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] mk(input bit ld, st, us, bb, hh, ww, dd);
        return {5'b0, dd, ww, hh, bb, us, st, ld, 3'b100};
    endfunction

    // reference: byte count from the size bits, then plain modular arithmetic on the address and data
    function automatic exp_t model(input logic [14:0] info, input logic [63:0] a, b, rs2, rdata,
                                   input logic [4:0] rd, input logic rwe);
        exp_t e;
        logic [63:0] ea, v, keep;
        int n, off, m;
        ea = a + b;
        n = info[9] ? 8 : info[8] ? 4 : info[7] ? 2 : 1;
        off = int'(ea % 8);
        e.mis = (ea % n) != 0;
        e.addr = ea - 64'(off);
        m = ((1 << n) - 1) << off;
        e.wmask = m[7:0];
        e.wdata = rs2 << (8 * off);
        v = rdata >> (8 * off);
        if (n < 8) begin
            keep = (64'd1 << (8 * n)) - 64'd1;
            v = v & keep;
            if ((!info[5] || n == 4) && v[8 * n - 1]) v = v | ~keep;
        end
        e.ld = e.mis ? 64'd0 : v;
        e.wen = info[3] && rwe && rd != 5'd0 && !e.mis;
        return e;
    endfunction

    // drives one op through accept, grant, response and writeback with the given stalls, recording what it saw
    task automatic xact(input logic [14:0] info, input logic [63:0] a, b, rs2, rdata, input logic [4:0] rd,
                        input logic rwe, input int gd, rvd, wd, output obs_t o);
        int rq, rs, wv;
        bit granted, done;
        o = '{default: '0};
        rq = 0; rs = 0; wv = 0; granted = 0; done = 0;
        o.ready_before = in_ready_o;
        in_valid_i = 1'b1; exu_info_bus_i = info; op1_i = a; op2_i = b; op2_jp_i = rs2;
        rd_idx_i = rd; rd_wr_en_i = rwe;
        @(posedge clk); #1;
        in_valid_i = 1'b0; exu_info_bus_i = 15'($urandom); op1_i = {$urandom, $urandom};
        op2_i = {$urandom, $urandom}; op2_jp_i = {$urandom, $urandom}; rd_idx_i = 5'($urandom);
        rd_wr_en_i = 1'($urandom_range(1));
        for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; wb_ready_i = 1'b0; mem_rdata_i = {$urandom, $urandom};
            if (in_ready_o) o.busy_ready = 1;
            if (wb_valid_o) begin
                if (wv == 0) begin
                    o.lat = cyc; o.wb_en = wb_en_o; o.idx = wb_rd_idx_o; o.data = wb_data_o; o.mis = misalign_o;
                end else if (wb_en_o !== o.wb_en || wb_rd_idx_o !== o.idx || wb_data_o !== o.data || misalign_o !== o.mis)
                    o.wb_unstable = 1;
                wv++;
                mem_gnt_i = 1'($urandom_range(1)); mem_rvalid_i = 1'($urandom_range(1));
                if (wv > wd) begin wb_ready_i = 1'b1; done = 1; end
            end else if (granted && info[3]) begin
                mem_gnt_i = 1'($urandom_range(1));
                rs++;
                if (rs > rvd) begin mem_rvalid_i = 1'b1; mem_rdata_i = rdata; end
            end else if (mem_req_o) begin
                if (rq == 0) begin
                    o.req_seen = 1; o.addr = mem_addr_o; o.we = mem_we_o; o.wdata = mem_wdata_o; o.wmask = mem_wmask_o;
                end else if (mem_addr_o !== o.addr || mem_we_o !== o.we || mem_wdata_o !== o.wdata || mem_wmask_o !== o.wmask)
                    o.req_unstable = 1;
                rq++;
                mem_rvalid_i = 1'($urandom_range(1));
                if (rq > gd) begin mem_gnt_i = 1'b1; granted = 1; end
            end
            @(posedge clk); #1;
        end
        o.timeout = !done;
        o.ready_after = in_ready_o;
        o.wbv_after = wb_valid_o;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; wb_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (in_ready_o !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready_o); else pass_cnt++;
        total_cnt++; if ({mem_req_o, mem_we_o} !== 2'b00) $display("FAIL reset_req_we: got %b expected 00", {mem_req_o, mem_we_o}); else pass_cnt++;
        total_cnt++; if ({mem_addr_o, mem_wdata_o, mem_wmask_o} !== '0) $display("FAIL reset_mem_bus: got addr %h wdata %h mask %h expected all zero", mem_addr_o, mem_wdata_o, mem_wmask_o); else pass_cnt++;
        total_cnt++; if ({wb_valid_o, wb_en_o, misalign_o, wb_rd_idx_o, wb_data_o} !== '0) $display("FAIL reset_wb: got valid %b en %b mis %b idx %0d data %h expected all zero", wb_valid_o, wb_en_o, misalign_o, wb_rd_idx_o, wb_data_o); else pass_cnt++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_sd();
        obs_t o;
        xact(mk(0, 1, 0, 0, 0, 0, 1), 64'h8000_0000, 64'd8, 64'h1122_3344_5566_7788, 64'd0, 5'd3, 1'b1, 0, 0, 0, o);
        total_cnt++; if (o.timeout) $display("FAIL sd_timeout: got timeout 1 expected 0"); else pass_cnt++;
        total_cnt++; if (o.addr !== 64'h8000_0008) $display("FAIL sd_addr: got %h expected %h", o.addr, 64'h8000_0008); else pass_cnt++;
        total_cnt++; if ({o.req_seen, o.we, o.wmask} !== {1'b1, 1'b1, 8'hFF}) $display("FAIL sd_req_mask: got req %b we %b mask %h expected 1 1 ff", o.req_seen, o.we, o.wmask); else pass_cnt++;
        total_cnt++; if (o.wdata !== 64'h1122_3344_5566_7788) $display("FAIL sd_wdata: got %h expected 1122334455667788", o.wdata); else pass_cnt++;
        total_cnt++; if (o.lat != 2) $display("FAIL sd_latency: got %0d expected 2", o.lat); else pass_cnt++;
        total_cnt++; if ({o.wb_en, o.mis} !== 2'b00) $display("FAIL sd_wb_en: got en %b mis %b expected 0 0", o.wb_en, o.mis); else pass_cnt++;
    endtask

    task automatic test_lb_lbu();
        obs_t o;
        xact(mk(1, 0, 0, 1, 0, 0, 0), 64'h8000_0000, 64'd3, 64'd0, 64'h0000_0000_8000_0000, 5'd5, 1'b1, 0, 0, 0, o);
        total_cnt++; if (o.data !== 64'hFFFF_FFFF_FFFF_FF80) $display("FAIL lb_data: got %h expected ffffffffffffff80", o.data); else pass_cnt++;
        total_cnt++; if ({o.wb_en, o.idx} !== {1'b1, 5'd5}) $display("FAIL lb_wb_en_idx: got en %b idx %0d expected 1 5", o.wb_en, o.idx); else pass_cnt++;
        total_cnt++; if (o.lat != 3) $display("FAIL lb_latency: got %0d expected 3", o.lat); else pass_cnt++;
        total_cnt++; if ({o.addr, o.we} !== {64'h8000_0000, 1'b0}) $display("FAIL lb_addr_we: got %h we %b expected 80000000 we 0", o.addr, o.we); else pass_cnt++;
        xact(mk(1, 0, 1, 1, 0, 0, 0), 64'h8000_0000, 64'd3, 64'd0, 64'h0000_0000_8000_0000, 5'd5, 1'b1, 0, 0, 0, o);
        total_cnt++; if (o.data !== 64'h80) $display("FAIL lbu_data: got %h expected 80", o.data); else pass_cnt++;
    endtask

    task automatic test_sh();
        obs_t o;
        xact(mk(0, 1, 0, 0, 1, 0, 0), 64'h8000_0004, 64'd2, 64'hABCD, 64'd0, 5'd1, 1'b1, 0, 0, 0, o);
        total_cnt++; if (o.wmask !== 8'hC0) $display("FAIL sh_mask: got %h expected c0", o.wmask); else pass_cnt++;
        total_cnt++; if (o.wdata !== 64'hABCD_0000_0000_0000) $display("FAIL sh_wdata: got %h expected abcd000000000000", o.wdata); else pass_cnt++;
        total_cnt++; if (o.addr !== 64'h8000_0000) $display("FAIL sh_addr: got %h expected 80000000", o.addr); else pass_cnt++;
    endtask

    task automatic test_lw_misalign();
        obs_t o;
        xact(mk(1, 0, 0, 0, 0, 1, 0), 64'h8000_0000, 64'd2, 64'd0, {$urandom, $urandom}, 5'd7, 1'b1, 0, 0, 0, o);
        total_cnt++; if (o.req_seen) $display("FAIL lw_mis_req: got mem_req 1 expected 0"); else pass_cnt++;
        total_cnt++; if ({o.mis, o.wb_en} !== 2'b10) $display("FAIL lw_mis_flags: got mis %b en %b expected 1 0", o.mis, o.wb_en); else pass_cnt++;
        total_cnt++; if (o.data !== 64'd0) $display("FAIL lw_mis_data: got %h expected 0", o.data); else pass_cnt++;
        total_cnt++; if (o.lat != 1) $display("FAIL lw_mis_latency: got %0d expected 1", o.lat); else pass_cnt++;
    endtask

    task automatic test_ld_stall();
        obs_t o;
        logic [63:0] r;
        r = {$urandom, $urandom};
        xact(mk(1, 0, 0, 0, 0, 0, 1), 64'h8000_0000, 64'h10, 64'd0, r, 5'd9, 1'b1, 3, 2, 2, o);
        total_cnt++; if (o.timeout) $display("FAIL ld_stall_timeout: got timeout 1 expected 0"); else pass_cnt++;
        total_cnt++; if (o.req_unstable || o.wb_unstable) $display("FAIL ld_stall_stable: got req_unstable %b wb_unstable %b expected 0 0", o.req_unstable, o.wb_unstable); else pass_cnt++;
        total_cnt++; if (o.data !== r) $display("FAIL ld_stall_data: got %h expected %h", o.data, r); else pass_cnt++;
        total_cnt++; if (o.lat != 8) $display("FAIL ld_stall_latency: got %0d expected 8", o.lat); else pass_cnt++;
        total_cnt++; if ({o.ready_after, o.wbv_after, o.busy_ready} !== 3'b100) $display("FAIL ld_stall_ready: got ready_after %b wbv_after %b ready_while_busy %b expected 1 0 0", o.ready_after, o.wbv_after, o.busy_ready); else pass_cnt++;
    endtask

    task automatic test_drop_non_ls();
        logic [14:0] infos [2];
        bit seen;
        infos[0] = {5'b0, 7'b0000001, 3'b001};
        infos[1] = mk(1, 1, 0, 0, 0, 0, 1);
        for (int k = 0; k < 2; k++) begin
            in_valid_i = 1'b1; exu_info_bus_i = infos[k]; op1_i = 64'h8000_0000; op2_i = 64'd0;
            @(posedge clk); #1;
            in_valid_i = 1'b0;
            seen = 0;
            for (int c = 0; c < 4; c++) begin
                if (mem_req_o || wb_valid_o || !in_ready_o) seen = 1;
                @(posedge clk); #1;
            end
            total_cnt++; if (seen) $display("FAIL drop_non_ls_%0d: got activity on req/wb/ready expected LSU to stay idle", k); else pass_cnt++;
        end
    endtask

    task automatic test_reset_in_rsp();
        bit bad;
        in_valid_i = 1'b1; exu_info_bus_i = mk(1, 0, 0, 0, 0, 0, 1); op1_i = 64'h8000_0000; op2_i = 64'd0;
        rd_idx_i = 5'd4; rd_wr_en_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        total_cnt++; if (mem_req_o !== 1'b1) $display("FAIL rst_rsp_req: got %b expected 1", mem_req_o); else pass_cnt++;
        mem_gnt_i = 1'b1;
        @(posedge clk); #1;
        mem_gnt_i = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = {$urandom, $urandom};
        total_cnt++; if (in_ready_o !== 1'b1 || {mem_req_o, mem_addr_o, wb_valid_o, wb_data_o} !== '0) $display("FAIL rst_rsp_idle: got ready %b req %b addr %h wb_valid %b expected 1 0 0 0", in_ready_o, mem_req_o, mem_addr_o, wb_valid_o); else pass_cnt++;
        @(posedge clk); #1;
        mem_rvalid_i = 1'b0;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            if (wb_valid_o || !in_ready_o || wb_data_o !== 64'd0) bad = 1;
            @(posedge clk); #1;
        end
        total_cnt++; if (bad) $display("FAIL rst_rsp_stale: got writeback or busy after stale rvalid expected idle"); else pass_cnt++;
    endtask

    task automatic test_back_to_back_random();
        obs_t o;
        exp_t e;
        logic [14:0] info;
        logic [63:0] a, b, rs2, rdata;
        logic [4:0] rd;
        logic [3:0] r;
        logic rwe;
        bit ld;
        int gd, rvd, wd, lat;
        for (int i = 0; i < 150; i++) begin
            ld = 1'($urandom_range(1));
            info = mk(ld, !ld, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                      1'($urandom_range(1)), 1'($urandom_range(2) == 0));
            a = {$urandom, $urandom}; r = 4'($urandom); b = {{60{r[3]}}, r};
            if ($urandom_range(2) != 0) a = a - ((a + b) % 8);
            rs2 = {$urandom, $urandom}; rdata = {$urandom, $urandom};
            rd = 5'($urandom_range(3) == 0 ? 0 : $urandom_range(31)); rwe = 1'($urandom_range(3) != 0);
            gd = $urandom_range(2); rvd = $urandom_range(2); wd = $urandom_range(2);
            e = model(info, a, b, rs2, rdata, rd, rwe);
            lat = e.mis ? 1 : ld ? 3 + gd + rvd : 2 + gd;
            xact(info, a, b, rs2, rdata, rd, rwe, gd, rvd, wd, o);
            total_cnt++; if (o.timeout || !o.ready_before) $display("FAIL rnd%0d_handshake: got timeout %b ready_before %b expected 0 1", i, o.timeout, o.ready_before); else pass_cnt++;
            total_cnt++; if (o.req_seen !== !e.mis) $display("FAIL rnd%0d_req_seen: got %b expected %b", i, o.req_seen, !e.mis); else pass_cnt++;
            total_cnt++; if (o.lat != lat) $display("FAIL rnd%0d_latency: got %0d expected %0d", i, o.lat, lat); else pass_cnt++;
            if (!e.mis) begin
                total_cnt++; if ({o.addr, o.we} !== {e.addr, !ld}) $display("FAIL rnd%0d_addr_we: got %h we %b expected %h we %b", i, o.addr, o.we, e.addr, !ld); else pass_cnt++;
            end
            if (!e.mis && !ld) begin
                total_cnt++; if ({o.wmask, o.wdata} !== {e.wmask, e.wdata}) $display("FAIL rnd%0d_store_lanes: got mask %h data %h expected mask %h data %h", i, o.wmask, o.wdata, e.wmask, e.wdata); else pass_cnt++;
            end
            total_cnt++; if ({o.wb_en, o.mis} !== {e.wen, e.mis}) $display("FAIL rnd%0d_wb_flags: got en %b mis %b expected en %b mis %b", i, o.wb_en, o.mis, e.wen, e.mis); else pass_cnt++;
            if (e.wen) begin
                total_cnt++; if (o.idx !== rd) $display("FAIL rnd%0d_wb_idx: got %0d expected %0d", i, o.idx, rd); else pass_cnt++;
            end
            if (ld || e.mis) begin
                total_cnt++; if (o.data !== e.ld) $display("FAIL rnd%0d_wb_data: got %h expected %h", i, o.data, e.ld); else pass_cnt++;
            end
            total_cnt++; if ({o.ready_after, o.wbv_after, o.busy_ready, o.req_unstable, o.wb_unstable} !== 5'b10000) $display("FAIL rnd%0d_flow: got ready_after %b wbv_after %b ready_busy %b req_unstable %b wb_unstable %b expected 1 0 0 0 0", i, o.ready_after, o.wbv_after, o.busy_ready, o.req_unstable, o.wb_unstable); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_sd();
        test_lb_lbu();
        test_sh();
        test_lw_misalign();
        test_ld_stall();
        test_drop_non_ls();
        test_reset_in_rsp();
        test_back_to_back_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
